// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the memory-bus DMA copier and the benches
// and software headers that target its memory map.
package mem_dma_pkg;

  localparam int DEF_ADDR_W = 27;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 16;

  localparam logic [DEF_ADDR_W-1:0] SDRAM_BASE    = 27'h000000;
  localparam logic [DEF_ADDR_W-1:0] SPIFLASH_BASE = 27'h800000;
  localparam logic [DEF_ADDR_W-1:0] VRAM32_BASE   = 27'hC00000;
  localparam logic [DEF_ADDR_W-1:0] VRAM8_BASE    = 27'hC00420;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4,
    S_FINISH  = 3'd5
  } dma_state_e;

endpackage

// File: rtl/mem_bus_master.sv
// Single-transaction initiator for the start/busy memory bus: latches a request,
// holds start until the responder has raised and then dropped busy.
module mem_bus_master
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_we,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_we,
  output logic              bus_start,
  input  logic              bus_busy,
  input  logic [DATA_W-1:0] bus_q
);

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_REQ  = 2'd1;
  localparam logic [1:0] PH_WAIT = 2'd2;

  logic [1:0] phase;

  assign ready = (phase == PH_IDLE);
  // Completion is seen in the same cycle busy is low, so the caller can capture q directly.
  assign done  = (phase == PH_WAIT) && !bus_busy;
  assign q     = bus_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase       <= PH_IDLE;
      bus_start   <= 1'b0;
      bus_we      <= 1'b0;
      bus_address <= '0;
      bus_data    <= '0;
    end else begin
      case (phase)
        PH_IDLE: if (req) begin
          phase       <= PH_REQ;
          bus_start   <= 1'b1;
          bus_address <= req_addr;
          bus_data    <= req_data;
          bus_we      <= req_we;
        end
        PH_REQ:  if (bus_busy) phase <= PH_WAIT;
        PH_WAIT: if (!bus_busy) begin
          phase     <= PH_IDLE;
          bus_start <= 1'b0;
          bus_we    <= 1'b0;
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_dma_copier.sv
// Block copy DMA over the CPU memory bus: one read then one write per word.
// Define MEM_DMA_FILL_EN to add a fill mode that writes cfg_fill without reading.
module mem_dma_copier
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [DATA_W-1:0] cfg_fill,
  input  logic              cfg_fill_mode,
  input  logic              cfg_go,
  input  logic              cfg_abort,
  output logic              dma_busy,
  output logic              dma_done,
  output logic [LEN_W-1:0]  dma_remaining,
  output logic [ADDR_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_we,
  output logic              bus_start,
  input  logic              bus_busy,
  input  logic [DATA_W-1:0] bus_q,
  input  logic              bus_initDone
);

  dma_state_e        state;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [DATA_W-1:0] data_q;
  logic              abort_pending, fill_mode_q;
  logic              go_ok, fill_sel;
  logic [DATA_W-1:0] fill_value;

  logic              mst_req, mst_ready, mst_done, mst_we;
  logic [ADDR_W-1:0] mst_addr;
  logic [DATA_W-1:0] mst_wdata, mst_q;

`ifdef MEM_DMA_FILL_EN
  assign fill_sel   = cfg_fill_mode;
  assign fill_value = cfg_fill;
`else
  assign fill_sel   = 1'b0;
  assign fill_value = '0;
`endif

  assign go_ok = cfg_go && bus_initDone;

  // The first request is issued straight from IDLE so start rises the cycle after go;
  // later requests wait in the REQ states until the master has dropped start.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mst_req   = 1'b0;
    mst_addr  = src_q;
    mst_wdata = data_q;
    mst_we    = 1'b0;
    case (state)
      S_IDLE: begin
        mst_req   = go_ok && (cfg_len != '0);
        mst_addr  = fill_sel ? cfg_dst : cfg_src;
        mst_wdata = fill_value;
        mst_we    = fill_sel;
      end
      S_RD_REQ: mst_req = mst_ready;
      S_WR_REQ: begin
        mst_req  = mst_ready;
        mst_addr = dst_q;
        mst_we   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      dma_busy      <= 1'b0;
      dma_done      <= 1'b0;
      dma_remaining <= '0;
      abort_pending <= 1'b0;
      fill_mode_q   <= 1'b0;
      src_q         <= '0;
      dst_q         <= '0;
      data_q        <= '0;
    end else begin
      dma_done <= 1'b0;
      if (state != S_IDLE && cfg_abort) abort_pending <= 1'b1;
      case (state)
        S_IDLE: if (go_ok) begin
          src_q         <= cfg_src;
          dst_q         <= cfg_dst;
          dma_remaining <= cfg_len;
          dma_busy      <= 1'b1;
          fill_mode_q   <= fill_sel;
          data_q        <= fill_value;
          if (cfg_len == '0)  state <= S_FINISH;
          else if (fill_sel)  state <= S_WR_REQ;
          else                state <= S_RD_REQ;
        end
        S_RD_REQ:  if (!mst_ready && bus_busy) state <= S_RD_WAIT;
        S_RD_WAIT: if (mst_done) begin
          data_q <= mst_q;
          state  <= S_WR_REQ;
        end
        S_WR_REQ:  if (!mst_ready && bus_busy) state <= S_WR_WAIT;
        S_WR_WAIT: if (mst_done) begin
          dma_remaining <= dma_remaining - LEN_W'(1);
          src_q         <= src_q + ADDR_W'(1);
          dst_q         <= dst_q + ADDR_W'(1);
          // An abort arriving in this very cycle also ends the block here.
          if (dma_remaining == LEN_W'(1) || abort_pending || cfg_abort) state <= S_FINISH;
          else if (fill_mode_q) state <= S_WR_REQ;
          else                  state <= S_RD_REQ;
        end
        S_FINISH: begin
          dma_done      <= 1'b1;
          dma_busy      <= 1'b0;
          abort_pending <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  mem_bus_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_master (
    .clk         (clk),
    .reset       (reset),
    .req         (mst_req),
    .req_addr    (mst_addr),
    .req_data    (mst_wdata),
    .req_we      (mst_we),
    .ready       (mst_ready),
    .done        (mst_done),
    .q           (mst_q),
    .bus_address (bus_address),
    .bus_data    (bus_data),
    .bus_we      (bus_we),
    .bus_start   (bus_start),
    .bus_busy    (bus_busy),
    .bus_q       (bus_q)
  );

endmodule

// File: tb/tb_mem_dma_copier.sv
// Self-checking bench for mem_dma_copier with a start/busy responder model and
// table-driven copy vectors; the fill sequence runs when MEM_DMA_FILL_EN is defined.
module tb_mem_dma_copier;
  import mem_dma_pkg::*;

  localparam int AW = 27;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] cfg_src = '0, cfg_dst = '0;
  logic [LW-1:0] cfg_len = '0;
  logic [DW-1:0] cfg_fill = '0;
  logic          cfg_fill_mode = 1'b0, cfg_go = 1'b0, cfg_abort = 1'b0;
  logic          dma_busy, dma_done;
  logic [LW-1:0] dma_remaining;
  logic [AW-1:0] bus_address;
  logic [DW-1:0] bus_data;
  logic          bus_we, bus_start;
  logic          bus_busy = 1'b0;
  logic [DW-1:0] bus_q = '0;
  logic          bus_initDone = 1'b1;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    int            exp_txns;
  } vec_t;

  txn_t          log_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            total = 0, bad = 0;
  int            hold_override = 0;
  int            proto_viol = 0, done_pulses = 0, start_rises = 0;
  bit            r_active = 1'b0;
  logic          r_we = 1'b0;

  always #5 clk = ~clk;

  mem_dma_copier dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_src       (cfg_src),
    .cfg_dst       (cfg_dst),
    .cfg_len       (cfg_len),
    .cfg_fill      (cfg_fill),
    .cfg_fill_mode (cfg_fill_mode),
    .cfg_go        (cfg_go),
    .cfg_abort     (cfg_abort),
    .dma_busy      (dma_busy),
    .dma_done      (dma_done),
    .dma_remaining (dma_remaining),
    .bus_address   (bus_address),
    .bus_data      (bus_data),
    .bus_we        (bus_we),
    .bus_start     (bus_start),
    .bus_busy      (bus_busy),
    .bus_q         (bus_q),
    .bus_initDone  (bus_initDone)
  );

  // Responder: raises busy on start, holds it 1..5 cycles (or hold_override), then completes.
  initial begin : responder
    int            r_cnt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    bit            r_released;
    txn_t          t;
    r_cnt = 0;
    r_released = 1'b0;
    r_addr = '0;
    r_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        r_active = 1'b0;
        r_released = 1'b0;
        bus_busy = 1'b0;
      end else if (r_active) begin
        if (!bus_start || bus_address != r_addr || bus_we != r_we) proto_viol++;
        r_cnt--;
        if (r_cnt == 0) begin
          bus_busy = 1'b0;
          r_active = 1'b0;
          r_released = 1'b1;
          if (r_we) mem[r_addr] = r_data;
          else bus_q = mem.exists(r_addr) ? mem[r_addr] : '0;
          t.we = r_we;
          t.addr = r_addr;
          t.data = r_we ? r_data : bus_q;
          log_q.push_back(t);
        end
      end else begin
        if (bus_start && r_released) proto_viol++;
        else if (bus_start) begin
          r_active = 1'b1;
          bus_busy = 1'b1;
          r_we = bus_we;
          r_addr = bus_address;
          r_data = bus_data;
          r_cnt = (hold_override > 0) ? hold_override : int'($urandom_range(5, 1));
        end
        r_released = 1'b0;
      end
    end
  end

  initial begin : monitor
    logic start_prev;
    start_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (dma_done) done_pulses++;
      if (bus_start && !start_prev) start_rises++;
      start_prev = bus_start;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_go(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n,
                       input logic fm, input logic [DW-1:0] fv);
    @(negedge clk);
    cfg_src = s;
    cfg_dst = d;
    cfg_len = n;
    cfg_fill_mode = fm;
    cfg_fill = fv;
    cfg_go = 1'b1;
    @(negedge clk);
    cfg_go = 1'b0;
  endtask

  task automatic wait_done(input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (dma_done) begin
        lat = i;
        break;
      end
    end
    check("done_seen", 64'(lat >= 0), 1);
  endtask

  task automatic wait_log(input int n, input int max);
    for (int i = 0; i < max && log_q.size() < n; i++) @(negedge clk);
    check("log_wait", 64'(log_q.size() >= n), 1);
  endtask

  initial begin : main
    vec_t          vecs[5];
    int            lat, base, d0, s0, v0, idx;
    logic [AW-1:0] a;

    vecs[0] = '{src: 27'h0000010, dst: VRAM8_BASE, len: 16'd4, exp_txns: 8};
    vecs[1] = '{src: 27'h0000000, dst: 27'h0000100, len: 16'd0, exp_txns: 0};
    vecs[2] = '{src: 27'h7FFFFFF, dst: 27'h0000200, len: 16'd2, exp_txns: 4};
    vecs[3] = '{src: 27'h0000020, dst: 27'h7FFFFFF, len: 16'd2, exp_txns: 4};
    vecs[4] = '{src: SDRAM_BASE,  dst: VRAM32_BASE, len: 16'd1, exp_txns: 2};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", dma_busy, 0);
    check("rst_done", dma_done, 0);
    check("rst_remaining", dma_remaining, 0);
    check("rst_start", bus_start, 0);
    check("rst_we", bus_we, 0);
    check("rst_address", bus_address, 0);
    check("rst_data", bus_data, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < int'(vecs[k].len); i++) begin
        a = vecs[k].src + AW'(i);
        mem[a] = 32'hA0 + DW'(i);
      end
      base = log_q.size();
      d0 = done_pulses;
      s0 = start_rises;
      v0 = proto_viol;
      do_go(vecs[k].src, vecs[k].dst, vecs[k].len, 1'b0, '0);
      check($sformatf("v%0d_busy_after_go", k), dma_busy, 1);
      check($sformatf("v%0d_start_after_go", k), bus_start, 64'(vecs[k].len != 0));
      wait_done(2000, lat);
      if (vecs[k].len == 0) check($sformatf("v%0d_len0_latency", k), 64'(lat + 1), 2);
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_txns", k), 64'(log_q.size() - base), 64'(vecs[k].exp_txns));
      check($sformatf("v%0d_start_count", k), 64'(start_rises - s0), 64'(vecs[k].exp_txns));
      check($sformatf("v%0d_done_pulses", k), 64'(done_pulses - d0), 1);
      check($sformatf("v%0d_remaining", k), dma_remaining, 0);
      check($sformatf("v%0d_busy_end", k), dma_busy, 0);
      check($sformatf("v%0d_protocol", k), 64'(proto_viol - v0), 0);
      for (int i = 0; i < int'(vecs[k].len); i++) begin
        idx = base + 2 * i;
        if (log_q.size() >= idx + 2) begin
          a = vecs[k].src + AW'(i);
          check($sformatf("v%0d_w%0d_rd_we", k, i), log_q[idx].we, 0);
          check($sformatf("v%0d_w%0d_rd_addr", k, i), log_q[idx].addr, a);
          a = vecs[k].dst + AW'(i);
          check($sformatf("v%0d_w%0d_wr_we", k, i), log_q[idx + 1].we, 1);
          check($sformatf("v%0d_w%0d_wr_addr", k, i), log_q[idx + 1].addr, a);
          check($sformatf("v%0d_w%0d_wr_data", k, i), log_q[idx + 1].data, 32'hA0 + DW'(i));
          check($sformatf("v%0d_w%0d_mem", k, i), mem.exists(a) ? mem[a] : 32'hFFFF_FFFF,
                32'hA0 + DW'(i));
        end
      end
    end

    // go while the memory system is not initialised is dropped
    s0 = start_rises;
    bus_initDone = 1'b0;
    do_go(27'h10, 27'h20, 16'd3, 1'b0, '0);
    repeat (5) @(negedge clk);
    check("noinit_busy", dma_busy, 0);
    check("noinit_starts", 64'(start_rises - s0), 0);
    bus_initDone = 1'b1;

    // go and abort in the same IDLE cycle: abort ignored
    base = log_q.size();
    cfg_abort = 1'b1;
    do_go(27'h400, 27'h500, 16'd2, 1'b0, '0);
    cfg_abort = 1'b0;
    wait_done(2000, lat);
    repeat (2) @(negedge clk);
    check("goabort_txns", 64'(log_q.size() - base), 4);
    check("goabort_remaining", dma_remaining, 0);

    // abort during the second word's read of a 10-word copy
    hold_override = 3;
    base = log_q.size();
    d0 = done_pulses;
    do_go(27'h100, 27'h300, 16'd10, 1'b0, '0);
    wait_log(base + 2, 200);
    for (int i = 0; i < 50 && !(r_active && !r_we); i++) @(negedge clk);
    check("abort_in_read", 64'(r_active && !r_we), 1);
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    wait_done(2000, lat);
    repeat (2) @(negedge clk);
    hold_override = 0;
    check("abort_txns", 64'(log_q.size() - base), 4);
    check("abort_remaining", dma_remaining, 8);
    check("abort_done_pulses", 64'(done_pulses - d0), 1);
    if (log_q.size() >= base + 4) begin
      check("abort_rd2_addr", log_q[base + 2].addr, 27'h101);
      check("abort_wr2_addr", log_q[base + 3].addr, 27'h301);
    end

    // abort must not linger into the next transfer
    base = log_q.size();
    do_go(27'h110, 27'h310, 16'd2, 1'b0, '0);
    wait_done(2000, lat);
    repeat (2) @(negedge clk);
    check("post_abort_txns", 64'(log_q.size() - base), 4);
    check("post_abort_remaining", dma_remaining, 0);

    // long busy hold with a second go mid-transfer
    hold_override = 20;
    base = log_q.size();
    d0 = done_pulses;
    v0 = proto_viol;
    do_go(27'h50, 27'h60, 16'd2, 1'b0, '0);
    repeat (8) @(negedge clk);
    check("hold_start_high", bus_start, 1);
    check("hold_busy_high", bus_busy, 1);
    do_go(27'h999, 27'h888, 16'd7, 1'b0, '0);
    wait_done(2000, lat);
    repeat (2) @(negedge clk);
    hold_override = 0;
    check("hold_txns", 64'(log_q.size() - base), 4);
    check("hold_protocol", 64'(proto_viol - v0), 0);
    check("hold_done_pulses", 64'(done_pulses - d0), 1);
    check("hold_remaining", dma_remaining, 0);
    if (log_q.size() >= base + 4) begin
      check("hold_rd1_addr", log_q[base].addr, 27'h50);
      check("hold_rd2_addr", log_q[base + 2].addr, 27'h51);
      check("hold_wr2_addr", log_q[base + 3].addr, 27'h61);
    end

    // reset in the middle of a copy
    base = log_q.size();
    do_go(27'h600, 27'h700, 16'd10, 1'b0, '0);
    wait_log(base + 2, 200);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_start", bus_start, 0);
    check("midrst_busy", dma_busy, 0);
    check("midrst_remaining", dma_remaining, 0);
    check("midrst_we", bus_we, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    base = log_q.size();
    do_go(27'h620, 27'h720, 16'd1, 1'b0, '0);
    wait_done(2000, lat);
    repeat (2) @(negedge clk);
    check("postrst_txns", 64'(log_q.size() - base), 2);

`ifdef MEM_DMA_FILL_EN
    // fill three words of VRAM32 without reading
    base = log_q.size();
    s0 = start_rises;
    do_go(27'h0, VRAM32_BASE, 16'd3, 1'b1, 32'hDEADBEEF);
    wait_done(2000, lat);
    repeat (2) @(negedge clk);
    check("fill_txns", 64'(log_q.size() - base), 3);
    check("fill_starts", 64'(start_rises - s0), 3);
    check("fill_remaining", dma_remaining, 0);
    for (int i = 0; i < 3; i++) begin
      if (log_q.size() >= base + i + 1) begin
        a = VRAM32_BASE + AW'(i);
        check($sformatf("fill_w%0d_we", i), log_q[base + i].we, 1);
        check($sformatf("fill_w%0d_addr", i), log_q[base + i].addr, a);
        check($sformatf("fill_w%0d_data", i), log_q[base + i].data, 32'hDEADBEEF);
      end
    end

    // reset after the first fill write
    base = log_q.size();
    do_go(27'h0, VRAM32_BASE + 27'h10, 16'd3, 1'b1, 32'h12345678);
    wait_log(base + 1, 200);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("fillrst_start", bus_start, 0);
    check("fillrst_busy", dma_busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
